// File: rtl/heap_sift_up_engine.sv
// heap_sift_up_engine: push-side min-heap insertion by iterative sift-up.
// Accepts one element per push handshake, writes it at entry[size] and then
// performs one parent compare-and-swap per clock until the heap invariant holds.
// The heap is exported flat, with the root in the MSB slice.
// Optional feature macro: HEAPSORT_SWAP_CNT_EN enables the saturating swap counter;
// when it is undefined, swap_cnt_o is tied to zero.
module heap_sift_up_engine #(
  parameter int unsigned DEPTH = 10,
  parameter int unsigned WIDTH = 16
) (
  input  logic                   system1000,
  input  logic                   system1000_rstn,
  input  logic                   push_valid_i,
  input  logic [WIDTH-1:0]       push_data_i,
  output logic                   push_ready_o,
  input  logic                   clr_i,
  output logic                   busy_o,
  output logic                   full_o,
  output logic [15:0]            size_o,
  output logic [DEPTH*WIDTH-1:0] heap_o,
  output logic [15:0]            swap_cnt_o
);

  // Index width into the entry array; live indices are always below DEPTH.
  localparam int unsigned IdxW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [0:0] {StIdle, StSift} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] heap_q [DEPTH];
  logic [WIDTH-1:0] heap_d [DEPTH];
  logic [15:0]      size_q, size_d;
  logic [15:0]      idx_q, idx_d;
  logic [15:0]      parent;
  logic             full;

`ifdef HEAPSORT_SWAP_CNT_EN
  logic             swap_inc;
  logic [15:0]      swap_cnt_q;
`endif

  assign full         = (size_q == 16'(DEPTH));
  assign parent       = (idx_q - 16'd1) >> 1;
  assign push_ready_o = (state_q == StIdle) && !full && !clr_i;
  assign busy_o       = (state_q == StSift);
  assign full_o       = full;
  assign size_o       = size_q;

  // State, heap array, size and cursor registers.
  always_ff @(posedge system1000 or negedge system1000_rstn) begin
    if (!system1000_rstn) begin
      state_q <= StIdle;
      size_q  <= 16'd0;
      idx_q   <= 16'd0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        heap_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      size_q  <= size_d;
      idx_q   <= idx_d;
      for (int i = 0; i < int'(DEPTH); i++) begin
        heap_q[i] <= heap_d[i];
      end
    end
  end

  // Next-state: clear dominates; IDLE accepts a push; SIFT does one compare-and-swap.
  always_comb begin
    state_d = state_q;
    size_d  = size_q;
    idx_d   = idx_q;
    heap_d  = heap_q;
`ifdef HEAPSORT_SWAP_CNT_EN
    swap_inc = 1'b0;
`endif
    if (clr_i) begin
      state_d = StIdle;
      size_d  = 16'd0;
      idx_d   = 16'd0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        heap_d[i] = '0;
      end
    end else begin
      unique case (state_q)
        StIdle: begin
          if (push_valid_i && push_ready_o) begin
            heap_d[size_q[IdxW-1:0]] = push_data_i;
            idx_d   = size_q;
            size_d  = size_q + 16'd1;
            state_d = StSift;
          end
        end
        StSift: begin
          // Ties stop the sift so equal keys are never swapped.
          if (idx_q == 16'd0 ||
              heap_q[parent[IdxW-1:0]] <= heap_q[idx_q[IdxW-1:0]]) begin
            state_d = StIdle;
          end else begin
            heap_d[parent[IdxW-1:0]] = heap_q[idx_q[IdxW-1:0]];
            heap_d[idx_q[IdxW-1:0]]  = heap_q[parent[IdxW-1:0]];
            idx_d = parent;
`ifdef HEAPSORT_SWAP_CNT_EN
            swap_inc = 1'b1;
`endif
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  // Flat export: entry 0 (root) occupies the most significant slice.
  always_comb begin
    heap_o = '0;
    for (int i = 0; i < int'(DEPTH); i++) begin
      heap_o[(int'(DEPTH) - i) * int'(WIDTH) - 1 -: WIDTH] = heap_q[i];
    end
  end

`ifdef HEAPSORT_SWAP_CNT_EN
  // Saturating swap counter; only reset clears it, clr_i leaves it alone.
  always_ff @(posedge system1000 or negedge system1000_rstn) begin
    if (!system1000_rstn) begin
      swap_cnt_q <= 16'd0;
    end else if (swap_inc && swap_cnt_q != 16'hFFFF) begin
      swap_cnt_q <= swap_cnt_q + 16'd1;
    end
  end

  assign swap_cnt_o = swap_cnt_q;
`else
  assign swap_cnt_o = 16'd0;
`endif

endmodule

// File: tb/tb_heap_sift_up_engine.sv
// Directed bench for heap_sift_up_engine (DEPTH=10, WIDTH=16).
module tb_heap_sift_up_engine;

  localparam int DEPTH = 10;
  localparam int WIDTH = 16;

`ifdef HEAPSORT_SWAP_CNT_EN
  localparam bit CntEn = 1'b1;
`else
  localparam bit CntEn = 1'b0;
`endif

  logic                   clk = 1'b0;
  logic                   rstn = 1'b0;
  logic                   push_valid = 1'b0;
  logic [WIDTH-1:0]       push_data = '0;
  logic                   clr = 1'b0;
  logic                   push_ready;
  logic                   busy;
  logic                   full;
  logic [15:0]            size;
  logic [DEPTH*WIDTH-1:0] heap;
  logic [15:0]            swap_cnt;

  int checks = 0;
  int failures = 0;

  heap_sift_up_engine #(
    .DEPTH(DEPTH),
    .WIDTH(WIDTH)
  ) dut (
    .system1000     (clk),
    .system1000_rstn(rstn),
    .push_valid_i   (push_valid),
    .push_data_i    (push_data),
    .push_ready_o   (push_ready),
    .clr_i          (clr),
    .busy_o         (busy),
    .full_o         (full),
    .size_o         (size),
    .heap_o         (heap),
    .swap_cnt_o     (swap_cnt)
  );

  always #5 clk = ~clk;

  function automatic logic [WIDTH-1:0] ent(input int i);
    return heap[(DEPTH - i) * WIDTH - 1 -: WIDTH];
  endfunction

  // Push one element and return the number of edges spent busy after the accept edge.
  task automatic push(input logic [15:0] d, output int busy_cycles);
    int n;
    @(negedge clk);
    push_valid = 1'b1;
    push_data  = d;
    n = 0;
    while (push_ready !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n >= 40) begin
      failures++;
      $display("FAIL push_accept data=%0d push_ready=%b required 1", d, push_ready);
    end
    @(posedge clk);
    #1;
    push_valid = 1'b0;
    n = 0;
    while (busy === 1'b1 && n < 40) begin
      @(posedge clk);
      #1;
      n++;
    end
    busy_cycles = n;
  endtask

  task automatic do_clear();
    @(negedge clk);
    clr = 1'b1;
    @(posedge clk);
    #1;
    @(negedge clk);
    clr = 1'b0;
  endtask

  task automatic test_reset();
    #2;
    checks++;
    if (size !== 16'd0 || heap !== '0 || busy !== 1'b0 || full !== 1'b0 ||
        swap_cnt !== 16'd0 || push_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset size=%0d heap=%h busy=%b full=%b swap=%0d ready=%b required 0,0,0,0,0,1",
               size, heap, busy, full, swap_cnt, push_ready);
    end
    @(negedge clk);
    rstn = 1'b1;
  endtask

  task automatic test_basic();
    logic [15:0] vals [4] = '{16'd5, 16'd3, 16'd8, 16'd1};
    int          expb [4] = '{1, 2, 1, 3};
    logic [15:0] exph [4] = '{16'd1, 16'd3, 16'd8, 16'd5};
    int bc;
    for (int i = 0; i < 4; i++) begin
      push(vals[i], bc);
      checks++;
      if (bc !== expb[i]) begin
        failures++;
        $display("FAIL basic_busy push=%0d busy_cycles=%0d required %0d", vals[i], bc, expb[i]);
      end
    end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (ent(i) !== exph[i]) begin
        failures++;
        $display("FAIL basic_entry%0d got=%0d required %0d", i, ent(i), exph[i]);
      end
    end
    checks++;
    if (size !== 16'd4) begin
      failures++;
      $display("FAIL basic_size got=%0d required 4", size);
    end
    checks++;
    if (swap_cnt !== (CntEn ? 16'd3 : 16'd0)) begin
      failures++;
      $display("FAIL basic_swap_cnt got=%0d required %0d", swap_cnt, CntEn ? 3 : 0);
    end
  endtask

  task automatic test_ties();
    int bc;
    do_clear();
    checks++;
    if (size !== 16'd0 || heap !== '0) begin
      failures++;
      $display("FAIL ties_clear size=%0d heap=%h required 0", size, heap);
    end
    push(16'd7, bc);
    push(16'd7, bc);
    checks++;
    if (bc !== 1) begin
      failures++;
      $display("FAIL ties_busy got=%0d required 1", bc);
    end
    checks++;
    if (ent(0) !== 16'd7 || ent(1) !== 16'd7 || size !== 16'd2) begin
      failures++;
      $display("FAIL ties_heap e0=%0d e1=%0d size=%0d required 7,7,2", ent(0), ent(1), size);
    end
    // clr_i must not touch the swap counter
    checks++;
    if (swap_cnt !== (CntEn ? 16'd3 : 16'd0)) begin
      failures++;
      $display("FAIL ties_swap_cnt got=%0d required %0d", swap_cnt, CntEn ? 3 : 0);
    end
  endtask

  task automatic test_full();
    int bc;
    do_clear();
    for (int i = 0; i < 10; i++) begin
      push(16'(100 - i), bc);
    end
    checks++;
    if (full !== 1'b1 || size !== 16'd10 || ent(0) !== 16'd91) begin
      failures++;
      $display("FAIL full_state full=%b size=%0d root=%0d required 1,10,91", full, size, ent(0));
    end
    for (int i = 1; i < 10; i++) begin
      checks++;
      if (ent((i - 1) >> 1) > ent(i)) begin
        failures++;
        $display("FAIL full_invariant idx=%0d parent=%0d child=%0d required parent<=child",
                 i, ent((i - 1) >> 1), ent(i));
      end
    end
    @(negedge clk);
    push_valid = 1'b1;
    push_data  = 16'd50;
    for (int c = 0; c < 5; c++) begin
      checks++;
      if (push_ready !== 1'b0) begin
        failures++;
        $display("FAIL full_ready cycle=%0d got=%b required 0", c, push_ready);
      end
      @(negedge clk);
    end
    push_valid = 1'b0;
    checks++;
    if (size !== 16'd10 || ent(0) !== 16'd91) begin
      failures++;
      $display("FAIL full_hold size=%0d root=%0d required 10,91", size, ent(0));
    end
  endtask

  task automatic test_clear_mid_sift();
    int bc;
    do_clear();
    push(16'd5, bc);
    push(16'd3, bc);
    push(16'd8, bc);
    @(negedge clk);
    push_valid = 1'b1;
    push_data  = 16'd1;
    @(posedge clk);
    #1;
    push_valid = 1'b0;
    checks++;
    if (busy !== 1'b1 || size !== 16'd4 || ent(3) !== 16'd1) begin
      failures++;
      $display("FAIL clr_pre busy=%b size=%0d e3=%0d required 1,4,1", busy, size, ent(3));
    end
    @(negedge clk);
    clr        = 1'b1;
    push_valid = 1'b1;
    push_data  = 16'd2;
    #1;
    checks++;
    if (push_ready !== 1'b0) begin
      failures++;
      $display("FAIL clr_ready got=%b required 0", push_ready);
    end
    @(posedge clk);
    #1;
    checks++;
    if (size !== 16'd0 || heap !== '0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL clr_after size=%0d heap=%h busy=%b required 0,0,0", size, heap, busy);
    end
    @(negedge clk);
    clr        = 1'b0;
    push_valid = 1'b0;
  endtask

  task automatic test_async_reset();
    int bc;
    do_clear();
    push(16'd5, bc);
    push(16'd3, bc);
    push(16'd8, bc);
    @(negedge clk);
    push_valid = 1'b1;
    push_data  = 16'd1;
    @(posedge clk);
    #1;
    push_valid = 1'b0;
    #2;
    rstn = 1'b0;
    #1;
    checks++;
    if (size !== 16'd0 || heap !== '0 || busy !== 1'b0 || full !== 1'b0 ||
        swap_cnt !== 16'd0 || push_ready !== 1'b1) begin
      failures++;
      $display("FAIL async_reset size=%0d heap=%h busy=%b full=%b swap=%0d ready=%b required 0,0,0,0,0,1",
               size, heap, busy, full, swap_cnt, push_ready);
    end
    @(negedge clk);
    rstn = 1'b1;
    push(16'd4, bc);
    checks++;
    if (ent(0) !== 16'd4 || size !== 16'd1 || swap_cnt !== 16'd0) begin
      failures++;
      $display("FAIL post_reset_push root=%0d size=%0d swap=%0d required 4,1,0",
               ent(0), size, swap_cnt);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_ties();
    test_full();
    test_clear_mid_sift();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
